// File: rtl/vctr_strm_mstr.sv
// Initiator for the vector-add streamer: reads two source vectors, pushes them
// into the streamer input FIFOs, starts it, drains sums into a result buffer.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_length, cmd_src*_base,
//   cmd_dst_base                  command fields, latched on accept
//   cmd_done                      one-cycle completion pulse
//   rd1_*/rd2_*                   source buffers, data one cycle after rd*_en
//   wr_*                          result buffer write port
//   data_in_v1*/data_in_v2*       streamer input FIFO pushes and full flags
//   data_out_en/data_out/
//   data_out_empty                streamer output FIFO pop, data next cycle
//   vector_length, start          streamer job length and start request
//   done, idle, ready             streamer status
module vctr_strm_mstr #(
    parameter int DATA_WIDTH  = 16,
    parameter int LENGTH_BITS = 8,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LENGTH_BITS-1:0] cmd_length,
    input  logic [ADDR_WIDTH-1:0]  cmd_src1_base,
    input  logic [ADDR_WIDTH-1:0]  cmd_src2_base,
    input  logic [ADDR_WIDTH-1:0]  cmd_dst_base,
    output logic                   cmd_done,
    output logic                   rd1_en,
    output logic [ADDR_WIDTH-1:0]  rd1_addr,
    input  logic [DATA_WIDTH-1:0]  rd1_data,
    output logic                   rd2_en,
    output logic [ADDR_WIDTH-1:0]  rd2_addr,
    input  logic [DATA_WIDTH-1:0]  rd2_data,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   data_in_v1_en,
    output logic [DATA_WIDTH-1:0]  data_in_v1,
    input  logic                   data_in_v1_full,
    output logic                   data_in_v2_en,
    output logic [DATA_WIDTH-1:0]  data_in_v2,
    input  logic                   data_in_v2_full,
    output logic                   data_out_en,
    input  logic [DATA_WIDTH-1:0]  data_out,
    input  logic                   data_out_empty,
    output logic [LENGTH_BITS-1:0] vector_length,
    output logic                   start,
    input  logic                   done,
    input  logic                   idle,
    input  logic                   ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_DRAIN,
        S_CPL
    } state_t;

    state_t state, state_nxt;

    logic [LENGTH_BITS-1:0] len_q;
    logic [LENGTH_BITS-1:0] rd_cnt;
    logic [LENGTH_BITS-1:0] push_cnt;
    logic [LENGTH_BITS-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0]  src1_q;
    logic [ADDR_WIDTH-1:0]  src2_q;
    logic [ADDR_WIDTH-1:0]  dst_q;
    logic                   rd_pend;
    logic                   pop_pend;
    logic                   hold_vld;
    logic [DATA_WIDTH-1:0]  hold1;
    logic [DATA_WIDTH-1:0]  hold2;

    logic                   accept;
    logic                   issue;
    logic                   pop;
    logic                   push_ok;
    logic                   push;
    logic                   pop_room;
    logic [LENGTH_BITS:0]   wr_inflight;

    // A word pair is pushed either from the hold register or straight from
    // the read issued last cycle; the two sources never coexist.
    assign push_ok     = !data_in_v1_full && !data_in_v2_full;
    assign push        = (hold_vld || rd_pend) && push_ok;
    assign wr_inflight = {1'b0, wr_cnt} + {{LENGTH_BITS{1'b0}}, pop_pend};
    assign pop_room    = wr_inflight < {1'b0, len_q};

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        start     = 1'b0;
        accept    = 1'b0;
        issue     = 1'b0;
        pop       = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_length == '0) ? S_CPL : S_START;
                end
            end
            S_START: begin
                start = 1'b1;
                if (ready) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                // A new read may overlap the push of the previous one only
                // if that push is certain to happen this cycle.
                issue = (rd_cnt < len_q) && !hold_vld
                        && (!rd_pend || push_ok);
                pop   = !data_out_empty && pop_room;
                if (push_cnt == len_q) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                pop = !data_out_empty && pop_room;
                if (wr_cnt == len_q && idle) state_nxt = S_CPL;
            end
            S_CPL: begin
                cmd_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign rd1_en        = issue;
    assign rd2_en        = issue;
    assign rd1_addr      = src1_q + ADDR_WIDTH'(rd_cnt);
    assign rd2_addr      = src2_q + ADDR_WIDTH'(rd_cnt);
    assign data_in_v1_en = push;
    assign data_in_v2_en = push;
    assign data_in_v1    = hold_vld ? hold1 : (rd_pend ? rd1_data : '0);
    assign data_in_v2    = hold_vld ? hold2 : (rd_pend ? rd2_data : '0);
    assign data_out_en   = pop;
    assign wr_en         = pop_pend;
    assign wr_addr       = dst_q + ADDR_WIDTH'(wr_cnt);
    assign wr_data       = pop_pend ? data_out : '0;
    assign vector_length = len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            rd_cnt   <= '0;
            push_cnt <= '0;
            wr_cnt   <= '0;
            rd_pend  <= 1'b0;
            pop_pend <= 1'b0;
            hold_vld <= 1'b0;
            hold1    <= '0;
            hold2    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                len_q    <= cmd_length;
                src1_q   <= cmd_src1_base;
                src2_q   <= cmd_src2_base;
                dst_q    <= cmd_dst_base;
                rd_cnt   <= '0;
                push_cnt <= '0;
                wr_cnt   <= '0;
                rd_pend  <= 1'b0;
                pop_pend <= 1'b0;
                hold_vld <= 1'b0;
            end else begin
                rd_pend  <= issue;
                pop_pend <= pop;
                if (issue)    rd_cnt   <= rd_cnt + 1'b1;
                if (push)     push_cnt <= push_cnt + 1'b1;
                if (pop_pend) wr_cnt   <= wr_cnt + 1'b1;
                // Blocked read data parks here until both FIFOs have room.
                if (rd_pend && !push_ok) begin
                    hold_vld <= 1'b1;
                    hold1    <= rd1_data;
                    hold2    <= rd2_data;
                end else if (hold_vld && push_ok) begin
                    hold_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vctr_strm_mstr.sv
// Bench for vctr_strm_mstr: source/result buffers plus a queue-based
// streamer model; results compared against element-wise sums of the sources.
module tb_vctr_strm_mstr;

    localparam int CAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_length = '0;
    logic [7:0]  cmd_src1_base = '0;
    logic [7:0]  cmd_src2_base = '0;
    logic [7:0]  cmd_dst_base = '0;
    logic        cmd_done;
    logic        rd1_en, rd2_en, wr_en;
    logic [7:0]  rd1_addr, rd2_addr, wr_addr;
    logic [15:0] rd1_data = '0, rd2_data = '0, wr_data;
    logic        data_in_v1_en, data_in_v2_en, data_out_en;
    logic [15:0] data_in_v1, data_in_v2;
    logic [15:0] data_out = '0;
    logic        data_in_v1_full, data_in_v2_full, data_out_empty;
    logic [7:0]  vector_length;
    logic        start;
    logic        done = 1'b0, idle = 1'b1, ready = 1'b0;

    logic full1_r = 1'b0, full2_r = 1'b0, emp_r = 1'b1;
    logic f_v1 = 1'b0, f_v2 = 1'b0, f_e = 1'b0;

    assign data_in_v1_full = full1_r | f_v1;
    assign data_in_v2_full = full2_r | f_v2;
    assign data_out_empty  = emp_r | f_e;

    vctr_strm_mstr dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_length(cmd_length),
        .cmd_src1_base(cmd_src1_base), .cmd_src2_base(cmd_src2_base),
        .cmd_dst_base(cmd_dst_base), .cmd_done(cmd_done),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
        .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .data_in_v1_en(data_in_v1_en), .data_in_v1(data_in_v1),
        .data_in_v1_full(data_in_v1_full),
        .data_in_v2_en(data_in_v2_en), .data_in_v2(data_in_v2),
        .data_in_v2_full(data_in_v2_full),
        .data_out_en(data_out_en), .data_out(data_out),
        .data_out_empty(data_out_empty),
        .vector_length(vector_length), .start(start),
        .done(done), .idle(idle), .ready(ready)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] d;
        bit         pat;
        bit         fv1;
        bit         fe;
        bit         rnd;
        bit         extra;
        int         exp_wr;
        int         exp_st;
    } vec_t;

    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];

    int tests = 0, fails = 0;

    // model-owned state
    logic [15:0] q1[$], q2[$], qo[$], wd[$];
    logic [7:0]  r1[$], r2[$], wa[$];
    int  cyc = 0, npush = 0, nstart = 0, ndone = 0, viol_p = 0;
    int  acc_cyc = -1, done_cyc = -1, produced = 0, tail = 0;
    int  mvlen = 0;
    bit  busy = 0, prev_start = 0;

    // snapshot / checker state
    logic        s_rd1_en, s_rd2_en, s_wr_en, s_v1_en, s_v2_en, s_oen;
    logic        s_start, s_acc, s_done;
    logic [7:0]  s_rd1_addr, s_rd2_addr, s_wr_addr, s_vlen;
    logic [15:0] s_wr_data, s_v1, s_v2;
    int  viol_n = 0, fcnt = 0, ecnt = 0;

    // bench-owned run state
    bit mode_fv1 = 0, mode_fe = 0, mode_rnd = 0;
    int np0 = 0, wa0 = 0, nd0 = 0, ns0 = 0, r10 = 0, vi0 = 0;

    always @(negedge clk) begin
        if (mode_rnd) begin
            f_v1 = ($urandom_range(0, 3) == 0);
            f_v2 = ($urandom_range(0, 3) == 0);
            f_e  = ($urandom_range(0, 2) == 0);
        end else begin
            f_v2 = 1'b0;
            if (mode_fv1 && (npush - np0) >= 3 && fcnt < 3) begin
                f_v1 = 1'b1;
                fcnt++;
            end else begin
                f_v1 = 1'b0;
                if (!mode_fv1) fcnt = 0;
            end
            if (mode_fe && (wa.size() - wa0) >= 3 && ecnt < 5) begin
                f_e = 1'b1;
                ecnt++;
            end else begin
                f_e = 1'b0;
                if (!mode_fe) ecnt = 0;
            end
        end
        #2;
        s_rd1_en   = rd1_en;
        s_rd2_en   = rd2_en;
        s_rd1_addr = rd1_addr;
        s_rd2_addr = rd2_addr;
        s_wr_en    = wr_en;
        s_wr_addr  = wr_addr;
        s_wr_data  = wr_data;
        s_v1_en    = data_in_v1_en;
        s_v2_en    = data_in_v2_en;
        s_v1       = data_in_v1;
        s_v2       = data_in_v2;
        s_oen      = data_out_en;
        s_start    = start;
        s_vlen     = vector_length;
        s_acc      = cmd_valid && cmd_ready;
        s_done     = cmd_done;
        if (s_v1_en != s_v2_en) viol_n++;
        if (s_rd1_en != s_rd2_en) viol_n++;
        if (s_v1_en && (data_in_v1_full || data_in_v2_full)) viol_n++;
    end

    // Streamer, source buffers and result buffer model.
    always @(posedge clk) begin
        logic [15:0] a, b;
        if (rst) begin
            q1.delete();
            q2.delete();
            qo.delete();
            busy = 0;
            tail = 0;
            produced = 0;
            prev_start = 0;
            full1_r  <= 1'b0;
            full2_r  <= 1'b0;
            emp_r    <= 1'b1;
            ready    <= 1'b0;
            idle     <= 1'b1;
            done     <= 1'b0;
            data_out <= '0;
            rd1_data <= '0;
            rd2_data <= '0;
        end else begin
            cyc++;
            if (s_v1_en) begin
                if (q1.size() >= CAP) viol_p++;
                q1.push_back(s_v1);
                npush++;
            end
            if (s_v2_en) begin
                if (q2.size() >= CAP) viol_p++;
                q2.push_back(s_v2);
            end
            if (s_oen) begin
                if (qo.size() == 0) begin
                    viol_p++;
                    data_out <= 16'hdead;
                end else begin
                    data_out <= qo.pop_front();
                end
            end
            if (busy && q1.size() > 0 && q2.size() > 0
                && qo.size() < CAP) begin
                a = q1.pop_front();
                b = q2.pop_front();
                qo.push_back(a + b);
                produced++;
            end
            done <= 1'b0;
            if (s_start && !busy) begin
                if (ready) begin
                    busy = 1;
                    produced = 0;
                    tail = 0;
                    mvlen = int'(s_vlen);
                    ready <= 1'b0;
                    idle  <= 1'b0;
                end else begin
                    ready <= 1'b1;
                end
            end
            if (s_start && !prev_start) nstart++;
            prev_start = s_start;
            if (busy && produced == mvlen && qo.size() == 0) begin
                tail++;
                if (tail == 3) begin
                    busy = 0;
                    done <= 1'b1;
                    idle <= 1'b1;
                end
            end
            full1_r <= (q1.size() >= CAP);
            full2_r <= (q2.size() >= CAP);
            emp_r   <= (qo.size() == 0);
            if (s_rd1_en) begin
                rd1_data <= mem1[s_rd1_addr];
                r1.push_back(s_rd1_addr);
            end
            if (s_rd2_en) begin
                rd2_data <= mem2[s_rd2_addr];
                r2.push_back(s_rd2_addr);
            end
            if (s_wr_en) begin
                wa.push_back(s_wr_addr);
                wd.push_back(s_wr_data);
            end
            if (s_acc) acc_cyc = cyc;
            if (s_done) begin
                done_cyc = cyc;
                ndone++;
            end
        end
    end

    task automatic chk(string nm, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rst(string tag);
        chk({tag, "_ctl"}, {rd1_en, rd2_en, wr_en, data_in_v1_en,
            data_in_v2_en, data_out_en, start, cmd_done, cmd_ready}, 1);
        chk({tag, "_addr"}, {rd1_addr, rd2_addr, wr_addr,
            vector_length}, 0);
        chk({tag, "_data"}, {wr_data, data_in_v1, data_in_v2}, 0);
    endtask

    task automatic fill(vec_t v);
        logic [7:0] a1, a2;
        for (int i = 0; i < v.len; i++) begin
            a1 = v.s1 + 8'(i);
            a2 = v.s2 + 8'(i);
            mem1[a1] = v.pat ? 16'(i + 1) : 16'($urandom);
            mem2[a2] = v.pat ? 16'(i + 9) : 16'($urandom);
        end
    endtask

    task automatic issue(vec_t v);
        @(negedge clk);
        mode_fv1 = v.fv1;
        mode_fe  = v.fe;
        mode_rnd = v.rnd;
        np0 = npush;
        wa0 = wa.size();
        nd0 = ndone;
        ns0 = nstart;
        r10 = r1.size();
        vi0 = viol_n + viol_p;
        cmd_valid     = 1'b1;
        cmd_length    = 8'(v.len);
        cmd_src1_base = v.s1;
        cmd_src2_base = v.s2;
        cmd_dst_base  = v.d;
        chk("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_check(vec_t v);
        logic [7:0]  a1, a2, ad;
        logic [15:0] e;
        int nw;
        for (int k = 0; k < 6000 && ndone == nd0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        mode_fv1 = 0;
        mode_fe  = 0;
        mode_rnd = 0;
        chk("cmd_done_cnt", ndone - nd0, 1);
        chk("start_cnt", nstart - ns0, v.exp_st);
        chk("write_cnt", wa.size() - wa0, v.exp_wr);
        chk("push_cnt", npush - np0, v.len);
        chk("read_cnt", r1.size() - r10, v.len);
        chk("protocol_viol", viol_n + viol_p - vi0, 0);
        if (v.len == 0) chk("len0_done_lat", done_cyc - acc_cyc, 1);
        else chk("vector_length", mvlen, v.len);
        nw = wa.size() - wa0;
        for (int i = 0; i < v.len && i < nw; i++) begin
            a1 = v.s1 + 8'(i);
            a2 = v.s2 + 8'(i);
            ad = v.d + 8'(i);
            e  = mem1[a1] + mem2[a2];
            chk("wr_addr", wa[wa0 + i], ad);
            chk("wr_data", wd[wa0 + i], e);
            chk("rd1_addr", r1[r10 + i], a1);
            chk("rd2_addr", r2[r10 + i], a2);
        end
    endtask

    task automatic run_cmd(vec_t v);
        fill(v);
        issue(v);
        if (v.extra) begin
            repeat (2) @(negedge clk);
            cmd_valid  = 1'b1;
            cmd_length = 8'd5;
            @(negedge clk);
            chk("busy_cmd_ready", cmd_ready, 0);
            cmd_valid = 1'b0;
        end
        finish_check(v);
    endtask

    vec_t tbl [7];
    vec_t v;

    initial begin
        tbl[0] = '{8,   8'h00, 8'h40, 8'h20, 1, 0, 0, 0, 0, 8,   1};
        tbl[1] = '{8,   8'h00, 8'h40, 8'h30, 1, 1, 0, 0, 0, 8,   1};
        tbl[2] = '{8,   8'h00, 8'h40, 8'h50, 1, 0, 1, 0, 0, 8,   1};
        tbl[3] = '{0,   8'h10, 8'h20, 8'h60, 1, 0, 0, 0, 0, 0,   0};
        tbl[4] = '{4,   8'hFE, 8'h80, 8'h70, 0, 0, 0, 0, 0, 4,   1};
        tbl[5] = '{6,   8'h10, 8'h90, 8'hF0, 0, 0, 0, 0, 1, 6,   1};
        tbl[6] = '{255, 8'h00, 8'h01, 8'h80, 0, 0, 0, 1, 0, 255, 1};

        repeat (2) @(negedge clk);
        chk_rst("reset");
        rst = 1'b0;

        for (int t = 0; t < 7; t++) run_cmd(tbl[t]);

        for (int r = 0; r < 8; r++) begin
            v = '{$urandom_range(1, 40), 8'($urandom), 8'($urandom),
                  8'($urandom), 0, 0, 0, 1, 0, 0, 1};
            v.exp_wr = v.len;
            run_cmd(v);
        end

        // Asynchronous reset in the middle of a job, then a fresh job.
        v = '{8, 8'h00, 8'h40, 8'hA0, 1, 0, 0, 0, 0, 8, 1};
        fill(v);
        issue(v);
        for (int k = 0; k < 200 && (npush - np0) < 4; k++) @(negedge clk);
        chk("rst_wait_push", (npush - np0) >= 4, 1);
        #3 rst = 1'b1;
        #1 chk_rst("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        v = '{2, 8'h05, 8'h45, 8'hC0, 1, 0, 0, 0, 0, 2, 1};
        run_cmd(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
